vg_fetch_ctrl: RTL and testbench

Vector-generator fetch/sequencing stage, directly downstream of the CPU address decoder. It consumes the decoder's `vggo`/`vgrst` strobes, walks the display list in vector RAM (the CPU's 0x2000–0x3FFF window, seen here as 16-bit words), executes flow-control opcodes internally and hands drawing instructions to the draw engine over a valid/ready handshake. It also produces the `halt` status bit the decoder returns at CPU address 0x0800.

---
 rtl/vg_pkg.sv | 32 +++
 rtl/vg_return_stack.sv | 56 +++++
 rtl/vg_fetch_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_vg_fetch_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vg_pkg.sv
// Shared types for the vector-generator fetch stage: opcodes, sequencer states
// and the opcode field position inside the first instruction word.
package vg_pkg;

    typedef enum logic [2:0] {
        OP_VCTR = 3'd0,
        OP_HALT = 3'd1,
        OP_SVEC = 3'd2,
        OP_STAT = 3'd3,
        OP_CNTR = 3'd4,
        OP_JSRL = 3'd5,
        OP_RTSL = 3'd6,
        OP_JMPL = 3'd7
    } vg_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_CAP0,
        ST_REQ1,
        ST_CAP1,
        ST_EMIT
    } vg_state_t;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;

    function automatic vg_op_t decode_op(input logic [15:0] word);
        return vg_op_t'(word[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/vg_return_stack.sv
// JSRL return-address LIFO: DEPTH entries of AW bits with push, pop and clear.
// Overflow/underflow are reported through full_o/empty_o; the caller decides.
module vg_return_stack #(
    parameter int AW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [AW-1:0] push_data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW-1:0] top_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DEPTH + 1);

    logic [SW-1:0] sp_q, sp_d;
    logic [AW-1:0] mem_q [DEPTH];

    assign full_o  = (sp_q == SW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_o   = mem_q[IW'(sp_q - SW'(1))];

    always_comb begin
        // NOTE: assign a default before any branch so the block never infers a latch.
        sp_d = sp_q;
        if (clear_i) begin
            sp_d = '0;
        end else if (push_i && !full_o) begin
            sp_d = sp_q + SW'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // NOTE: the entry array has no reset; only slots below sp_q are ever read, and reset clears sp_q.
    always_ff @(posedge clk) begin
        if (push_i && !full_o && !clear_i) begin
            mem_q[IW'(sp_q)] <= push_data_i;
        end
    end

endmodule

// File: rtl/vg_fetch_ctrl.sv
// Vector-generator fetch/sequencer: walks the display list, runs flow control
// internally and hands drawing instructions to the draw engine.
module vg_fetch_ctrl
    import vg_pkg::*;
#(
    parameter int AW          = 12,
    parameter int STACK_DEPTH = 4,
    parameter int MAX_INSTR   = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vggo,
    input  logic          vgrst,
    output logic          vmem_rd,
    output logic [AW-1:0] vmem_addr,
    input  logic [15:0]   vmem_data,
    output logic          out_valid,
    input  logic          out_ready,
    output vg_op_t        out_op,
    output logic [15:0]   out_w0,
    output logic [15:0]   out_w1,
    output logic          halt,
    output logic          err
);

    localparam int CW = $clog2(MAX_INSTR + 1);

    vg_state_t     state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   w0_q, w0_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          halt_q;
    logic          vggo_q;
    logic          out_valid_q, out_valid_d;
    vg_op_t        out_op_q, out_op_d;
    logic [15:0]   out_w0_q, out_w0_d;
    logic [15:0]   out_w1_q, out_w1_d;

    logic          stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    logic [AW-1:0] stk_top;

    vg_op_t        op;
    logic [AW-1:0] target;
    logic [AW-1:0] pc_inc;

    assign op     = decode_op(vmem_data);
    assign target = vmem_data[AW-1:0];
    assign pc_inc = pc_q + AW'(1);

    vg_return_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .clear_i     (stk_clear),
        .push_data_i (pc_inc),
        .full_o      (stk_full),
        .empty_o     (stk_empty),
        .top_o       (stk_top)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        w0_d        = w0_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_w0_d    = out_w0_q;
        out_w1_d    = out_w1_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_clear   = 1'b0;

        if (vgrst) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            stk_clear   = 1'b1;
            pc_d        = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (vggo && !vggo_q) begin
                        state_d   = ST_REQ0;
                        pc_d      = '0;
                        cnt_d     = '0;
                        err_d     = 1'b0;
                        stk_clear = 1'b1;
                    end
                end
                ST_REQ0: state_d = ST_CAP0;
                ST_CAP0: begin
                    w0_d  = vmem_data;
                    pc_d  = pc_inc;
                    cnt_d = cnt_q + CW'(1);
                    // The instruction that brings the count to the limit is not executed.
                    if (cnt_q == CW'(MAX_INSTR - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        unique case (op)
                            OP_VCTR: state_d = ST_REQ1;
                            OP_HALT: state_d = ST_IDLE;
                            OP_JMPL: begin
                                pc_d    = target;
                                state_d = ST_REQ0;
                            end
                            OP_JSRL: begin
                                if (stk_full) begin
                                    err_d   = 1'b1;
                                    state_d = ST_IDLE;
                                end else begin
                                    stk_push = 1'b1;
                                    pc_d     = target;
                                    state_d  = ST_REQ0;
                                end
                            end
                            OP_RTSL: begin
                                if (stk_empty) begin
                                    err_d   = 1'b1;
                                    state_d = ST_IDLE;
                                end else begin
                                    stk_pop = 1'b1;
                                    pc_d    = stk_top;
                                    state_d = ST_REQ0;
                                end
                            end
                            default: begin
                                out_valid_d = 1'b1;
                                out_op_d    = op;
                                out_w0_d    = vmem_data;
                                out_w1_d    = '0;
                                state_d     = ST_EMIT;
                            end
                        endcase
                    end
                end
                ST_REQ1: state_d = ST_CAP1;
                ST_CAP1: begin
                    pc_d        = pc_inc;
                    out_valid_d = 1'b1;
                    out_op_d    = OP_VCTR;
                    out_w0_d    = w0_q;
                    out_w1_d    = vmem_data;
                    state_d     = ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_REQ0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            w0_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            halt_q      <= 1'b1;
            vggo_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_op_q    <= OP_VCTR;
            out_w0_q    <= '0;
            out_w1_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            w0_q        <= w0_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            halt_q      <= (state_d == ST_IDLE);
            vggo_q      <= vggo;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_w0_q    <= out_w0_d;
            out_w1_q    <= out_w1_d;
        end
    end

    assign vmem_rd   = (state_q == ST_REQ0) || (state_q == ST_REQ1);
    assign vmem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_w0    = out_w0_q;
    assign out_w1    = out_w1_q;
    assign halt      = halt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vg_fetch_ctrl.sv
// Bench for vg_fetch_ctrl: a program-level reference model predicts fetch
// addresses, emitted instructions, frame length and error for each frame.
module tb_vg_fetch_ctrl;

    localparam int MEM_WORDS   = 4096;
    localparam int STACK_DEPTH = 4;
    localparam int MAX_INSTR   = 4096;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] w0;
        logic [15:0] w1;
    } emit_t;

    logic        clk, rst, vggo, vgrst, vmem_rd, out_valid, out_ready, halt, err;
    logic [11:0] vmem_addr;
    logic [15:0] vmem_data, out_w0, out_w1;
    logic [2:0]  out_op;

    logic [15:0] mem [MEM_WORDS];
    emit_t       exp_emits[$];
    int          exp_addrs[$];
    int          exp_cycles;
    bit          exp_err, runaway;
    int          n_cmp, n_bad;
    bit          rd_prev;

    vg_fetch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .vggo      (vggo),
        .vgrst     (vgrst),
        .vmem_rd   (vmem_rd),
        .vmem_addr (vmem_addr),
        .vmem_data (vmem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_w0    (out_w0),
        .out_w1    (out_w1),
        .halt      (halt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    // Vector RAM responder: data for a read stays put through the following
    // cycle and is scrambled whenever no capture can be pending.
    always @(negedge clk) begin
        if (vmem_rd === 1'b1) begin
            vmem_data = mem[vmem_addr];
            rd_prev   = 1'b1;
        end else begin
            if (!rd_prev) vmem_data = 16'($urandom);
            rd_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'h2000;
    endtask

    // Walks the program as the display-list rules describe it.
    task automatic ref_model();
        int          pc, cnt, op;
        int          stk[$];
        logic [15:0] w, w1;
        bit          done;
        exp_emits.delete();
        exp_addrs.delete();
        exp_err = 0; runaway = 0; exp_cycles = 0;
        pc = 0; cnt = 0; done = 0;
        while (!done) begin
            exp_addrs.push_back(pc);
            w = mem[pc];
            exp_cycles += 2;
            cnt++;
            if (cnt == MAX_INSTR) begin
                exp_err = 1; runaway = 1; done = 1;
            end else begin
                pc = (pc + 1) % MEM_WORDS;
                op = int'(w) / 8192;
                case (op)
                    0: begin
                        exp_addrs.push_back(pc);
                        w1 = mem[pc];
                        pc = (pc + 1) % MEM_WORDS;
                        exp_emits.push_back('{op: 3'd0, w0: w, w1: w1});
                        exp_cycles += 3;
                    end
                    1: done = 1;
                    5: begin
                        if (stk.size() == STACK_DEPTH) begin
                            exp_err = 1; done = 1;
                        end else begin
                            stk.push_back(pc);
                            pc = int'(w) % MEM_WORDS;
                        end
                    end
                    6: begin
                        if (stk.size() == 0) begin
                            exp_err = 1; done = 1;
                        end else begin
                            pc = stk.pop_back();
                        end
                    end
                    7: pc = int'(w) % MEM_WORDS;
                    default: begin
                        exp_emits.push_back('{op: 3'(op), w0: w, w1: 16'h0});
                        exp_cycles += 1;
                    end
                endcase
            end
        end
    endtask

    // force_stall >= 0 holds out_ready low that many cycles per instruction; -1 randomizes.
    task automatic run_frame(input int force_stall);
        int    busy, stall_sum, stall_left, limit;
        bit    done;
        emit_t e;
        ref_model();
        limit      = exp_cycles + 6 * exp_emits.size() + 20;
        busy       = 0;
        stall_sum  = 0;
        stall_left = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
        out_ready  = 1'b0;
        @(negedge clk);
        vggo = 1'b1;
        @(negedge clk);
        vggo = 1'b0;
        check("first_rd", vmem_rd, 1);
        check("halt_drop", halt, 0);
        check("err_clear", err, 0);
        done = 0;
        while (!done) begin
            if (halt) begin
                done = 1;
            end else begin
                busy++;
                if (vmem_rd) begin
                    if (exp_addrs.size() == 0) check("rd_extra", vmem_rd, 0);
                    else check("fetch_addr", vmem_addr, exp_addrs.pop_front());
                end
                if (out_valid) begin
                    if (exp_emits.size() == 0) begin
                        check("emit_extra", out_valid, 0);
                        out_ready = 1'b1;
                    end else begin
                        e = exp_emits[0];
                        check("out_op", out_op, e.op);
                        check("out_w0", out_w0, e.w0);
                        check("out_w1", out_w1, e.w1);
                        if (stall_left > 0) begin
                            out_ready = 1'b0;
                            stall_left--;
                            stall_sum++;
                        end else begin
                            out_ready = 1'b1;
                            void'(exp_emits.pop_front());
                            stall_left = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
                        end
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
                if (busy > limit) begin
                    check("frame_timeout", halt, 1);
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        out_ready = 1'b0;
        check("busy_cycles", busy, exp_cycles + stall_sum);
        check("frame_err", err, exp_err);
        check("emits_left", exp_emits.size(), 0);
        check("fetches_left", exp_addrs.size(), 0);
    endtask

    task automatic gen_random();
        int r, op;
        clear_mem();
        for (int i = 0; i < 64; i++) begin
            r = $urandom_range(0, 99);
            op = (r < 15) ? 1 : (r < 35) ? 0 : (r < 55) ? 2 : (r < 65) ? 3 :
                 (r < 80) ? 4 : (r < 87) ? 5 : (r < 93) ? 6 : 7;
            if (op == 5 || op == 7) mem[i] = {3'(op), 13'($urandom_range(0, 63))};
            else mem[i] = {3'(op), 13'($urandom)};
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; rd_prev = 0;
        rst = 1'b1; vggo = 1'b0; vgrst = 1'b0; out_ready = 1'b0; vmem_data = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_halt", halt, 1);
        check("rst_err", err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rd", vmem_rd, 0);
        check("rst_addr", vmem_addr, 0);
        check("rst_op", out_op, 0);
        check("rst_w0", out_w0, 0);
        check("rst_w1", out_w1, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_rd", vmem_rd, 0);

        // CNTR then HALT
        mem[0] = 16'h8000; mem[1] = 16'h2000;
        run_frame(0);

        // VCTR with a long draw-engine stall
        clear_mem();
        mem[0] = 16'h0010; mem[1] = 16'h0020; mem[2] = 16'h2000;
        run_frame(5);

        // subroutine call and return
        clear_mem();
        mem[0] = 16'hA100; mem[1] = 16'h2000; mem[12'h100] = 16'h4000; mem[12'h101] = 16'hC000;
        run_frame(-1);

        // five nested calls overflow a four-deep stack
        clear_mem();
        mem[0] = 16'hA010; mem[12'h10] = 16'hA020; mem[12'h20] = 16'hA030;
        mem[12'h30] = 16'hA040; mem[12'h40] = 16'hA050;
        run_frame(-1);
        check("ovf_halt", halt, 1);

        // return with nothing on the stack; err survives a vgrst pulse
        clear_mem();
        mem[0] = 16'hC000;
        run_frame(-1);
        @(negedge clk); vgrst = 1'b1;
        @(negedge clk); vgrst = 1'b0;
        check("vgrst_keeps_err", err, 1);
        check("vgrst_idle_halt", halt, 1);

        // self-jump runs away, then a clean frame clears err
        clear_mem();
        mem[0] = 16'hE000;
        run_frame(-1);
        clear_mem();
        mem[0] = 16'h8000; mem[1] = 16'h2000;
        run_frame(-1);

        // vgrst and vggo in the same cycle
        @(negedge clk); vggo = 1'b1; vgrst = 1'b1;
        @(negedge clk); vggo = 1'b0; vgrst = 1'b0;
        check("both_halt", halt, 1);
        check("both_valid", out_valid, 0);
        check("both_rd", vmem_rd, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("both_no_fetch", vmem_rd, 0);
        end

        // vgrst while an instruction waits in EMIT
        out_ready = 1'b0;
        @(negedge clk); vggo = 1'b1;
        @(negedge clk); vggo = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        check("emit_seen", out_valid, 1);
        vgrst = 1'b1;
        @(negedge clk); vgrst = 1'b0;
        check("emit_rst_valid", out_valid, 0);
        check("emit_rst_halt", halt, 1);
        check("emit_rst_rd", vmem_rd, 0);
        @(negedge clk);
        check("emit_rst_no_fetch", vmem_rd, 0);

        // asynchronous reset mid-frame; no restart without a new vggo edge
        @(negedge clk); vggo = 1'b1;
        @(negedge clk); vggo = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1;
        check("arst_halt", halt, 1);
        check("arst_valid", out_valid, 0);
        check("arst_rd", vmem_rd, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_stays_idle", vmem_rd, 0);
        end

        // randomized programs that terminate in bounded time
        for (int f = 0; f < 12; f++) begin
            do begin
                gen_random();
                ref_model();
            end while (runaway || exp_cycles > 1500);
            run_frame(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
